sa3_driver: RTL and testbench
=============================

Name: sa3_driver

Overview:
Initiator-side sequencer for the 3x3 systolic convolution array.
- Collects a 4x4 activation tile and a 3x3 filter from an 8-bit valid/ready byte stream.
- Presents both as flat buses, holds the array's run enable until its completion pulse, then latches the four 2x2 results.
- Streams the results back out as bytes with a valid/ready/last handshake.
- Sits between the on-chip buffer fabric and the array.

Parameters:
DONE_TIMEOUT, 32, max cycles in RUN awaiting done_sa3 before abort (array nominally needs 17)
TW, 6, width of the watchdog counter; must hold DONE_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input byte valid
in_ready  output  1  driver accepts input byte
in_data  input  8  operand byte
a_mat  output  128  activations row-major: a11=[7:0], a12=[15:8] … a44=[127:120]
b_mat  output  72  filter row-major: b11=[7:0] … b33=[71:64]
active_sa3  output  1  array run enable
done_sa3  input  1  array completion pulse
c_res  input  32  array results: c11=[7:0], c12=[15:8], c21=[23:16], c22=[31:24]
out_valid  output  1  result byte valid
out_ready  input  1  downstream accepts result byte
out_data  output  8  result byte
out_last  output  1  high with the 4th result byte
busy  output  1  state != LOAD
err  output  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state=LOAD, byte count=0, watchdog=0, a_mat/b_mat/result regs=0. active_sa3=0, out_valid=0, out_last=0, err=0, in_ready=1.
- All outputs are registered or decoded from registered state only; no combinational path from done_sa3, in_valid or out_ready to any output.
- LOAD state:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready stores in_data at index k, then k++.
  - k=0..15 writes a_mat element k; k=16..24 writes b_mat element k-16.
  - Bubbles (in_valid=0) do not advance k.
  - The first accepted byte clears err.
  - Acceptance of byte k=24 sets k=0 and transitions to RUN. active_sa3=1 from the next cycle.
- RUN state:
  - in_ready=0, active_sa3=1, watchdog increments each cycle.
  - a_mat/b_mat are frozen from RUN entry until the next LOAD write.
  - Cycle with done_sa3=1: at that edge, latch c_res into the result regs, clear active_sa3, go to DRAIN. The array sees active low on its next cycle and holds in its idle state.
  - Watchdog reaches DONE_TIMEOUT with no done: set err=1, load result regs with 0, clear active_sa3, go to DRAIN.
  - done_sa3 and timeout on the same cycle: done wins, err stays 0.
- DRAIN state:
  - out_valid=1.
  - out_data = result byte j (j=0..3 → c11, c12, c21, c22).
  - out_last = (j==3).
  - j advances only on out_valid&&out_ready; out_data/out_last stay stable while stalled.
  - Transfer with j=3 sets j=0, out_valid=0, and returns to LOAD.
- done_sa3 outside RUN is ignored; no state or result change.
- Back-to-back tiles: a new LOAD starts the cycle after the last DRAIN transfer. There is no operand persistence across tiles; all 25 bytes are reloaded.
- Results are 8-bit as delivered by the array (wrap-around arithmetic inside the array). The driver does no saturation or sign handling.
- Reset mid-RUN or mid-DRAIN: active_sa3 and out_valid drop immediately, all counters clear, and partial results are discarded.

Test Plan:
1. Bench connects the real array. Stream a=1..16 row-major, b all 1 with no bubbles, out_ready=1 → active_sa3 rises 1 cycle after byte 25, done after 17 cycles. Output bytes 54, 63, 90, 99; out_last on 99; err=0.
2. Same tile with in_valid toggling every other cycle → identical results; LOAD lasts 49 cycles; k never advances on bubbles.
3. Stub array holding done_sa3=0 → active_sa3 falls after exactly 32 RUN cycles; err=1; four 0x00 bytes emitted. The next tile's first accepted byte clears err.
4. Scenario 1 with out_ready=0 for 5 cycles at j=1 → out_data holds 63 with out_valid=1 throughout; no byte lost or duplicated.
5. Assert rst 10 cycles into RUN → active_sa3=0 the same cycle; busy=0, in_ready=1. A fresh full tile afterwards produces correct results.
6. Pulse done_sa3 during LOAD at k=7 → ignored; k continues and the tile completes normally.

Source files
------------

// File: rtl/sa3_driver.sv
// rtl/sa3_driver.sv - operand loader, run/watchdog sequencer and result drain for the 3x3 systolic array
module sa3_driver #(
    parameter int DONE_TIMEOUT = 32,
    parameter int TW           = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [127:0] a_mat,
    output logic [71:0]  b_mat,
    output logic         active_sa3,
    input  logic         done_sa3,
    input  logic [31:0]  c_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [TW-1:0] WD_LAST = TW'(DONE_TIMEOUT - 1);

    state_t        state;
    logic [4:0]    k;
    logic [1:0]    j;
    logic [TW-1:0] wd;
    logic [31:0]   res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            k     <= 5'd0;
            j     <= 2'd0;
            wd    <= '0;
            res   <= 32'd0;
            a_mat <= 128'd0;
            b_mat <= 72'd0;
            err   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        // For k=16..24 the low four bits of k are exactly the filter index.
                        if (k < 5'd16)
                            a_mat[{k[3:0], 3'b000} +: 8] <= in_data;
                        else
                            b_mat[{k[3:0], 3'b000} +: 8] <= in_data;
                        if (k == 5'd0)
                            err <= 1'b0;
                        if (k == 5'd24) begin
                            k     <= 5'd0;
                            wd    <= '0;
                            state <= RUN;
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                end
                RUN: begin
                    // A done on the timeout cycle still counts as success.
                    if (done_sa3) begin
                        res   <= c_res;
                        wd    <= '0;
                        state <= DRAIN;
                    end else if (wd == WD_LAST) begin
                        res   <= 32'd0;
                        err   <= 1'b1;
                        wd    <= '0;
                        state <= DRAIN;
                    end else begin
                        wd <= wd + TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (j == 2'd3) begin
                            j     <= 2'd0;
                            state <= LOAD;
                        end else begin
                            j <= j + 2'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign in_ready   = (state == LOAD);
    assign active_sa3 = (state == RUN);
    assign out_valid  = (state == DRAIN);
    assign out_data   = res[{j, 3'b000} +: 8];
    assign out_last   = (state == DRAIN) && (j == 2'd3);
    assign busy       = (state != LOAD);

endmodule

// File: tb/tb_sa3_driver.sv
// tb/tb_sa3_driver.sv - table-driven and randomized bench for sa3_driver with a behavioural array stub
module tb_sa3_driver;

    localparam int DT = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [127:0] a_mat;
    logic [71:0]  b_mat;
    logic         active_sa3;
    logic         done_sa3;
    logic [31:0]  c_res;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    sa3_driver #(.DONE_TIMEOUT(DT), .TW(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_mat(a_mat), .b_mat(b_mat),
        .active_sa3(active_sa3), .done_sa3(done_sa3), .c_res(c_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    typedef struct {
        int kind;      // 0 = ramp a=1..16, b=1; 1 = random bytes
        int bmode;     // 0 = no bubbles, 1 = alternate, 2 = random
        int lat;       // RUN cycle on which the stub pulses done; 0 = never
        int stall_j;
        int stall_n;
        int done_k;    // stray done pulse during LOAD at this k; -1 = none
        int exp_err;
        int exp_run;
        int exp_load;  // 0 = not deterministic
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  tile [25];
    logic [7:0]  exp_b [4];
    logic [7:0]  ramp_res [4];
    int          prev_err = 0;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] conv_tile(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int q = 0; q < 3; q++)
                s += int'(tile[(r + i) * 4 + c + q]) * int'(tile[16 + i * 3 + q]);
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] conv_bus(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int q = 0; q < 3; q++)
                s += int'(a_mat[((r + i) * 4 + c + q) * 8 +: 8]) * int'(b_mat[(i * 3 + q) * 8 +: 8]);
        return 8'(s % 256);
    endfunction

    task automatic send_tile(input int bmode, input int done_k, output int cycles);
        int  k = 0;
        bit  clr_seen = 0;
        logic rdy;
        cycles = 0;
        while (k < 25 && cycles < 300) begin
            @(negedge clk);
            if (cycles == 0) check("err_before_load", err, 128'(prev_err));
            if (k == 1 && !clr_seen) begin
                check("err_cleared", err, 0);
                clr_seen = 1;
            end
            in_valid = (bmode == 0) ? 1'b1 : (bmode == 1) ? ((cycles % 2) == 0) : 1'($urandom_range(0, 1));
            in_data  = tile[k];
            done_sa3 = (done_k >= 0 && k == done_k);
            c_res    = 32'hA5A5_A5A5;
            rdy      = in_ready;
            @(posedge clk);
            if (in_valid && rdy) k++;
            cycles++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        done_sa3 = 1'b0;
        check("bytes_accepted", k, 25);
    endtask

    task automatic run_array(input int lat, output int n);
        n = 0;
        while (active_sa3 && n < 100) begin
            n++;
            if (n == lat) begin
                c_res    = {conv_bus(1, 1), conv_bus(1, 0), conv_bus(0, 1), conv_bus(0, 0)};
                done_sa3 = 1'b1;
            end else begin
                c_res    = $urandom;
                done_sa3 = 1'b0;
            end
            @(negedge clk);
        end
        done_sa3 = 1'b0;
    endtask

    task automatic drain(input int stall_j, input int stall_n);
        int got = 0;
        int cyc = 0;
        int st = 0;
        while (got < 4 && cyc < 100) begin
            if (got == stall_j && st < stall_n) begin
                out_ready = 1'b0;
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, exp_b[got]);
                st++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    check($sformatf("byte%0d", got), out_data, exp_b[got]);
                    check($sformatf("last%0d", got), out_last, (got == 3));
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("bytes_drained", got, 4);
    endtask

    task automatic run_vec(input vec_t v);
        int load_cyc;
        int run_cyc;
        for (int i = 0; i < 25; i++)
            tile[i] = (v.kind == 0) ? ((i < 16) ? 8'(i + 1) : 8'd1) : 8'($urandom);
        for (int q = 0; q < 4; q++)
            exp_b[q] = v.exp_err ? 8'd0 : conv_tile(q / 2, q % 2);
        out_ready = 1'b1;
        send_tile(v.bmode, v.done_k, load_cyc);
        if (v.exp_load != 0) check("load_cycles", load_cyc, 128'(v.exp_load));
        check("active_rise", active_sa3, 1);
        check("in_ready_run", in_ready, 0);
        for (int i = 0; i < 16; i++) check("a_elem", a_mat[i * 8 +: 8], tile[i]);
        for (int i = 0; i < 9; i++) check("b_elem", b_mat[i * 8 +: 8], tile[16 + i]);
        run_array(v.lat, run_cyc);
        check("run_cycles", run_cyc, 128'(v.exp_run));
        check("err_after_run", err, 128'(v.exp_err));
        if (v.kind == 0 && v.exp_err == 0)
            for (int q = 0; q < 4; q++) check("ramp_model", exp_b[q], ramp_res[q]);
        drain(v.stall_j, v.stall_n);
        check("out_valid_idle", out_valid, 0);
        check("busy_idle", busy, 0);
        prev_err = v.exp_err;
    endtask

    initial begin
        int n;
        vec_t rv;
        ramp_res[0] = 8'd54; ramp_res[1] = 8'd63; ramp_res[2] = 8'd90; ramp_res[3] = 8'd99;
        vecs[0] = '{0, 0, 17, -1, 0, -1, 0, 17, 25};
        vecs[1] = '{0, 1, 17, -1, 0, -1, 0, 17, 49};
        vecs[2] = '{0, 0, 0, -1, 0, -1, 1, 32, 25};
        vecs[3] = '{0, 0, 17, 1, 5, -1, 0, 17, 25};
        vecs[4] = '{1, 0, 32, -1, 0, -1, 0, 32, 25};
        vecs[5] = '{1, 2, 1, 3, 2, -1, 0, 1, 0};
        vecs[6] = '{0, 0, 17, -1, 0, 7, 0, 17, 25};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; done_sa3 = 1'b0; c_res = 32'd0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_active", active_sa3, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_a_mat", a_mat, 0);
        check("rst_b_mat", b_mat, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // reset 10 cycles into RUN, then a fresh tile
        for (int i = 0; i < 25; i++) tile[i] = 8'(i + 3);
        send_tile(0, -1, n);
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("active_before_rst", active_sa3, 1);
        rst = 1'b1;
        #1;
        check("rst_run_active", active_sa3, 0);
        check("rst_run_busy", busy, 0);
        check("rst_run_in_ready", in_ready, 1);
        check("rst_run_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_err = 0;
        run_vec(vecs[0]);

        for (int r = 0; r < 8; r++) begin
            rv.kind = 1;
            rv.bmode = $urandom_range(0, 2);
            rv.lat = $urandom_range(1, 40);
            rv.stall_j = $urandom_range(0, 3);
            rv.stall_n = $urandom_range(0, 4);
            rv.done_k = -1;
            rv.exp_err = (rv.lat > DT) ? 1 : 0;
            rv.exp_run = (rv.lat > DT) ? DT : rv.lat;
            rv.exp_load = (rv.bmode == 0) ? 25 : (rv.bmode == 1) ? 49 : 0;
            run_vec(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
